// File: rtl/msk_affine_pipe.sv
// msk_affine_pipe: pipelined, flow-controlled masked affine step.
//
// Per lane i, share 0 of the Boolean sharing is XORed with the public
// constant in_const[i]; shares 1..d-1 pass through untouched. The
// transformed beat then travels through LATENCY register stages that
// collapse bubbles independently under back-pressure.
//
// Parameters:
//   d       - shares per masked bit (>= 1)
//   count   - number of masked lanes (>= 1)
//   LATENCY - number of register stages (>= 1)
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset (clears valids and data)
//   in_data   - input sharings, lane i at [i*d +: d], share 0 at bit i*d
//   in_const  - affine constant per lane, sampled together with in_data
//   in_valid  - input beat present
//   in_ready  - unit accepts a beat this cycle
//   out_data  - output sharings, same layout as in_data
//   out_valid - out_data holds a beat
//   out_ready - downstream accepts the beat this cycle
//
// Handshake: a beat moves on a side when valid && ready are both high at a
// rising clock edge. in_ready never depends on in_valid, and out_valid never
// depends on out_ready; once out_valid is high, out_data holds until taken.

module msk_affine_pipe #(
  parameter int d       = 2,
  parameter int count   = 1,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [count*d-1:0]   in_data,
  input  logic [count-1:0]     in_const,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [count*d-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W = count * d;

  // Affine step: only bit i*d (share 0 of lane i) sees the constant. Every
  // other bit is a straight wire, so no two shares meet in any gate.
  logic [W-1:0] in_xf;

  always_comb begin
    in_xf = in_data;
    for (int i = 0; i < count; i++) begin
      in_xf[i*d] = in_data[i*d] ^ in_const[i];
    end
  end

  // Index 0 is the stage nearest the input, index LATENCY-1 drives the output.
  logic [W-1:0]       data_q [LATENCY];
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] adv;

  // A stage may load when it is empty or everything downstream of it can
  // advance. Walking backwards, that is "out_ready, or any stage from here to
  // the output is empty", accumulated in free_chain.
  always_comb begin
    logic free_chain;
    free_chain = out_ready;
    adv        = '0;
    for (int s = LATENCY - 1; s >= 0; s--) begin
      free_chain = free_chain | ~v_q[s];
      adv[s]     = free_chain;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

  // Data loads even for bubbles; it is never observed because the valid bit
  // travelling with it is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v_q[0]    <= in_valid;
        data_q[0] <= in_xf;
      end
      for (int s = 1; s < LATENCY; s++) begin
        if (adv[s]) begin
          v_q[s]    <= v_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

endmodule

// File: doc/msk_affine_pipe.md
Name: msk_affine_pipe

Overview:
- Pipelined, flow-controlled masked affine unit: per lane, XORs a public constant bit into a Boolean-masked sharing (constant 1 = masked NOT, 0 = pass-through).
- Successor to the combinational masked inverter: adds per-lane runtime constants, a configurable register depth, and a valid/ready handshake with per-stage bubble collapsing.
- Sits between masked S-box/linear layers wherever a registered affine step with back-pressure is needed.
- The constant touches share 0 only; shares 1..d-1 are copied unchanged.

Parameters:
d, 2, number of shares per masked bit (>=1).
count, 1, number of masked lanes (>=1).
LATENCY, 2, pipeline register stages (>=1).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  count*d  input sharings; lane i occupies bits [i*d +: d], share 0 at i*d.
in_const  input  count  public affine constant per lane, sampled with in_data.
in_valid  input  1  input beat present.
in_ready  output  1  unit accepts a beat this cycle.
out_data  output  count*d  output sharings, same layout as in_data.
out_valid  output  1  out_data holds a beat.
out_ready  input  1  downstream accepts the beat this cycle.

Behaviour:
- Function, per lane i, evaluated at stage 1 entry:
  - out share 0 = in share 0 XOR in_const[i].
  - out shares 1..d-1 = in shares 1..d-1, bit-exact.
  - For d=1 the lane is a plain XOR.
  - in_const never mixes into shares 1..d-1; no cross-share combinational path.
- Stages: LATENCY stages s=1..LATENCY. Each holds data[count*d] and valid bit v[s]. Stage LATENCY drives out_data/out_valid directly from registers; no combinational path from in_data to out_data.
- Transfers: input beat accepted when in_valid && in_ready. Output beat consumed when out_valid && out_ready.
- Advance rule, evaluated from the last stage backward:
  - adv[LATENCY] = !v[LATENCY] || out_ready.
  - adv[s] = !v[s] || adv[s+1].
  - in_ready = adv[1], combinational from out_ready and the valid bits only, never from in_valid.
- Stage update when adv[s]:
  - Stage s loads stage s-1 (stage 0 = input side, whose valid = in_valid).
  - v[s] takes the upstream valid. A bubble is loaded as v=0; its data may hold but must not be observed.
  - When !adv[s], stage s holds data and valid.
- Capacity: LATENCY beats in flight. Throughput 1 beat/cycle with out_ready held high.
- Latency: a beat accepted at edge k appears on out_data with out_valid=1 after edge k+LATENCY-1, when all stages ahead of it are free.
- Full: all v=1 and out_ready=0 -> in_ready=0; out_data/out_valid stable until taken.
- Empty: all v=0 -> out_valid=0, in_ready=1.
- Simultaneous: full pipeline with out_ready=1 accepts a new beat in the same cycle (in_ready=1).
- Stall: while out_valid=1 and out_ready=0, out_data must not change.
- Reset:
  - rst_n low clears all v[s] and all data registers to 0 asynchronously.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1.
  - In-flight beats are dropped, no partial output.
  - Reset release is synchronous to clk; the first acceptance is possible at the first edge after release.
- Masking:
  - Every share bit crosses every stage as an independent flop.
  - No share values are mixed in any register or gate.
  - Glitch-free by construction; the block is affine.

Test Plan:
- d=2, count=2, LATENCY=2, out_ready=1. Input lane0 = {s1=1,s0=0}, lane1 = {s1=0,s0=1}, in_const=2'b01, one beat. Expect:
  - in_data = 4'b0110, out_data = 4'b0111 exactly 2 cycles later, out_valid high for one cycle;
  - unmasked values: lane0 1->0, lane1 1->1.
- Streaming: 8 back-to-back beats with random data and constants, out_ready=1 -> in_ready constantly 1, 8 outputs in order at 1/cycle, each share 0 = in share0 ^ const and other shares unchanged.
- Back-pressure: hold out_ready=0 and push beats.
  - in_ready drops after exactly LATENCY=2 accepted beats.
  - out_data is frozen while stalled.
  - Raising out_ready drains both beats in order, and a third beat is accepted in the same cycle.
- Bubble collapse: LATENCY=3. Insert gaps (in_valid 1,0,1) with out_ready=0.
  - Beats pack into stages 3 and 2.
  - in_ready stays 1 until 3 beats are held.
- Reset mid-operation: pull rst_n low between edges with 2 beats in flight -> out_valid=0, out_data=0 immediately. After release, no stale beat emerges and the next beat returns with normal latency.
- Sweep d=1 and d=4, count=3, LATENCY=1. Compare against the reference model and check that no in_const bit influences shares 1..d-1.
